// File: rtl/key_step_counter_if.sv
// key_step_counter_if: groups the pushbutton-side inputs and the count-side
// outputs of key_step_counter into one bundle.
//
// Handshake: step is the valid qualifier for count. It is high for exactly one
// cycle after count has been written, and that cycle's count is the new value.
// There is no ready: the consumer (the 7-segment decoder) always accepts.
// key_n, up_down, enable and clr are level inputs with no handshake.
// dbg_state exposes the debounce FSM state for observation only.
interface key_step_counter_if #(
  parameter int WIDTH = 3
);
  logic             key_n;
  logic             up_down;
  logic             enable;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             step;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output key_n, up_down, enable, clr,
    input  count, step, busy, dbg_state
  );

  modport slave (
    input  key_n, up_down, enable, clr,
    output count, step, busy, dbg_state
  );
endinterface

// File: rtl/key_step_counter.sv
// key_step_counter: debounced pushbutton that steps a WIDTH-bit up/down count.
// The raw key passes a 2-flop synchronizer, then a 4-state FSM accepts a press
// only after DEBOUNCE_CYCLES stable cycles. Each accepted press steps the count
// once (no auto-repeat); step pulses for one cycle after every count write.
// Optional build macro KEY_STEP_COUNTER_SATURATE_EN: count saturates at its
// limits instead of wrapping (a saturated press gives no step pulse).
module key_step_counter #(
  parameter int WIDTH           = 3,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic            clk,
  input  logic            reset_n,
  key_step_counter_if.slave bus
);

  localparam int                DCNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0]  CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_ONE  = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [1:0]        sync_q;
  logic              key_s;
  logic              confirm;
  logic [WIDTH-1:0]  count_q, count_nx;
  logic              step_q;

  assign key_s = sync_q[1];

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.key_n};
    end
  end

  // FSM state and debounce counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state logic; confirm marks the single press-accept edge.
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    confirm = 1'b0;
    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = DEB_PRESS;
          dcnt_d  = '0;
        end
      end
      DEB_PRESS: begin
        if (key_s) begin
          state_d = IDLE;
          dcnt_d  = '0;
        end else if (dcnt_q == DCNT_MAX) begin
          state_d = HELD;
          confirm = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      HELD: begin
        if (key_s) begin
          state_d = DEB_RELEASE;
          dcnt_d  = '0;
        end
      end
      DEB_RELEASE: begin
        if (!key_s) begin
          state_d = HELD;
        end else if (dcnt_q == DCNT_MAX) begin
          state_d = IDLE;
        end else begin
          dcnt_d = dcnt_q + DCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        dcnt_d  = '0;
      end
    endcase
  end

  // Candidate count for a confirmed press in the sampled direction.
  always_comb begin
    count_nx = count_q;
`ifdef KEY_STEP_COUNTER_SATURATE_EN
    if (bus.up_down) begin
      if (count_q != CNT_MAX) count_nx = count_q + CNT_ONE;
    end else begin
      if (count_q != '0) count_nx = count_q - CNT_ONE;
    end
`else
    if (bus.up_down) begin
      count_nx = count_q + CNT_ONE;
    end else begin
      count_nx = count_q - CNT_ONE;
    end
`endif
  end

  // Count register and step pulse; clr takes priority over a press.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      if (bus.clr) begin
        count_q <= '0;
        step_q  <= 1'b1;
      end else if (confirm && bus.enable && (count_nx != count_q)) begin
        count_q <= count_nx;
        step_q  <= 1'b1;
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.step      = step_q;
  assign bus.busy      = (state_q == DEB_PRESS) || (state_q == DEB_RELEASE);
  assign bus.dbg_state = state_q;

endmodule

// File: doc/key_step_counter.md
KEY_STEP_COUNTER -- requirements
Module: key_step_counter

Interface
REQ-001 Parameter WIDTH, default 3: width of the count output; the default matches the 3-bit code range of the downstream 7-segment decoder.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000: number of stable cycles required to accept a key edge (10 ms at 50 MHz); legal range >= 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1: reset, synchronous and active-low; the block has exactly one clock.
REQ-005 Port key_n, input, 1: raw pushbutton, active-low, asynchronous to clk, bouncy.
REQ-006 Port up_down, input, 1: step direction, 1 = increment, 0 = decrement; sampled only on the press-confirm edge.
REQ-007 Port enable, input, 1: 1 = confirmed presses step the count; 0 = presses are debounced but do not step.
REQ-008 Port clr, input, 1: synchronous clear of count to 0.
REQ-009 Port count, output, WIDTH: registered count value; drives the decoder's switch input.
REQ-010 Port step, output, 1: one-cycle pulse in the cycle after any write that changes count or any clr.
REQ-011 Port busy, output, 1: high when the FSM is in DEB_PRESS or DEB_RELEASE.

Function
REQ-012 key_n SHALL pass through a 2-flop synchronizer; only the second flop output (key_s) is used.
REQ-013 FSM states SHALL be IDLE, DEB_PRESS, HELD, DEB_RELEASE, plus a debounce counter dcnt of ceil(log2(DEBOUNCE_CYCLES)) bits.
REQ-014 IDLE: key_s == 0 -> DEB_PRESS and dcnt = 0; otherwise stay in IDLE.
REQ-015 DEB_PRESS: key_s == 1 -> IDLE and dcnt = 0 (bounce rejected); key_s == 0 and dcnt == DEBOUNCE_CYCLES-1 -> HELD (press confirmed); otherwise dcnt + 1.
REQ-016 HELD: key_s == 1 -> DEB_RELEASE and dcnt = 0; otherwise stay in HELD; a held key SHALL NOT auto-repeat.
REQ-017 DEB_RELEASE: key_s == 0 -> HELD with no count change; key_s == 1 and dcnt == DEBOUNCE_CYCLES-1 -> IDLE; otherwise dcnt + 1.
REQ-018 On the press-confirm edge with enable == 1, count SHALL become count+1 if up_down == 1 and count-1 if up_down == 0, modulo 2^WIDTH.
REQ-019 Latency: with key_n held low from before rising edge 1, count SHALL update at rising edge DEBOUNCE_CYCLES+3, and step SHALL be high for exactly the following cycle.
REQ-020 Wrap: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1; step SHALL assert on wrap.
REQ-021 clr == 1 SHALL set count = 0 and assert step on the next cycle; clr SHALL NOT affect the FSM or dcnt.
REQ-022 clr together with press-confirm on the same edge: clr wins, count = 0, and only one step pulse is produced.
REQ-023 enable == 0 at press-confirm: FSM SHALL still go to HELD; count unchanged; no step.
REQ-024 step SHALL never be high for two consecutive cycles from a single event.

Reset
REQ-025 reset_n == 0 at a rising edge SHALL set count = 0, step = 0, state = IDLE, dcnt = 0, and both synchronizer flops = 1 (released).
REQ-026 A reset during DEB_PRESS, HELD or DEB_RELEASE SHALL abort the operation with no count change.
REQ-027 A key still held low after reset release is a new press and SHALL be debounced and counted once.

Configuration
REQ-028 Macro KEY_STEP_COUNTER_SATURATE_EN defined: count SHALL saturate, so up at 2^WIDTH-1 and down at 0 leave count unchanged with no step pulse.
REQ-029 Macro KEY_STEP_COUNTER_SATURATE_EN undefined: wrap behaviour per REQ-020.

Verification (bench overrides DEBOUNCE_CYCLES = 4, WIDTH = 3)
REQ-030 Reset: reset_n low 2 cycles with key_n = 0 -> count = 0, step = 0, busy = 0 during reset.
REQ-031 Clean press: up_down = 1, enable = 1, key_n low for 20 cycles from count 0 -> count = 1 at edge 7, step high 1 cycle, no further change; release 20 cycles -> no change, busy returns to 0.
REQ-032 Bounce: key_n low 2 cycles, high 1, low 2, high 10 -> count unchanged, no step; release bounce inside HELD (high 2, low 1) -> no extra count.
REQ-033 Wrap: 8 up presses from 0 -> sequence 1..7 then 0; 1 down press from 0 -> 7; with KEY_STEP_COUNTER_SATURATE_EN: count holds at 7 and at 0 with no step.
REQ-034 clr: count = 5 with clr on the press-confirm edge -> count = 0 and exactly one step pulse; enable = 0 press -> count unchanged.
REQ-035 Reset mid-debounce: reset_n low 1 cycle at dcnt = 2 with key still held -> no count; after reset, count = 1 exactly once at DEBOUNCE_CYCLES+3 edges later.
